// File: rtl/rip_ro_pkg.sv
// rip_ro_pkg: shared types for the ring-oscillator measurement stage.
// Holds the FSM encoding and synchroniser defaults.
package rip_ro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    MEASURE = 2'd2,
    HOLD    = 2'd3
  } ro_state_e;

  localparam int RO_SYNC_DEFAULT = 2;

  // bits needed to count 0..max(a,b)-1
  function automatic int ro_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rip_sync_ff.sv
// rip_sync_ff: multi-stage synchroniser for an asynchronous level.
// Reusable for any single-bit input crossing into clk.
module rip_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] ff;

  // shift the raw input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rip_ro_counter.sv
// rip_ro_counter: gates a ring oscillator and counts its rising edges.
// Optional TRNG outputs (rnd_bit, rnd_raw) under macro RIP_RO_TRNG_EN.
module rip_ro_counter
  import rip_ro_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1024,
  parameter int WARMUP_CYCLES = 16,
  parameter int COUNT_W       = 16,
  parameter int SYNC_STAGES   = RO_SYNC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ro_in,
  output logic               ro_en,
  output logic               busy,
  output logic [COUNT_W-1:0] count,
  output logic               sat,
  output logic               valid,
  input  logic               ready
`ifdef RIP_RO_TRNG_EN
  ,
  output logic               rnd_bit,
  output logic               rnd_raw
`endif
);

  localparam int PW = ro_cnt_w(WINDOW_CYCLES, WARMUP_CYCLES);
  localparam logic [PW-1:0] WARM_LAST = PW'(WARMUP_CYCLES - 1);
  localparam logic [PW-1:0] WIN_LAST  = PW'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CMAX = '1;

  ro_state_e state;
  ro_state_e nstate;

  logic [PW-1:0]      phase;
  logic               ro_s;
  logic               ro_prev;
  logic               e;
  logic [COUNT_W-1:0] ecnt;
  logic               esat;
  logic               go;
  logic               win_start;
  logic               win_end;
  logic               take;

  rip_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ro_in),
    .q   (ro_s)
  );

  assign e         = ro_s & ~ro_prev;
  assign go        = (state == IDLE) && start;
  assign win_start = (state == WARMUP) && (phase == WARM_LAST);
  assign win_end   = (state == MEASURE) && (phase == WIN_LAST);
  assign take      = valid && ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // next-state decode
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start)     nstate = WARMUP;
      WARMUP:  if (win_start) nstate = MEASURE;
      MEASURE: if (win_end)   nstate = HOLD;
      HOLD:    if (take)      nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  // output decode
  always_comb begin
    busy = (state != IDLE);
  end

  // cycle counter for warmup and window, cleared on every phase change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (go || win_start || win_end) begin
      phase <= '0;
    end else if (state == WARMUP || state == MEASURE) begin
      phase <= phase + 1'b1;
    end
  end

  // oscillator enable spans warmup and measure only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro_en <= 1'b0;
    end else if (go) begin
      ro_en <= 1'b1;
    end else if (win_end) begin
      ro_en <= 1'b0;
    end
  end

  // saturating rising-edge counter, live only inside the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro_prev <= 1'b0;
      ecnt    <= '0;
      esat    <= 1'b0;
    end else begin
      ro_prev <= ro_s;
      if (win_start) begin
        ecnt <= '0;
        esat <= 1'b0;
      end else if (state == MEASURE && e) begin
        if (ecnt == CMAX) begin
          esat <= 1'b1;
        end else begin
          ecnt <= ecnt + 1'b1;
        end
      end
    end
  end

  // result capture on the first HOLD cycle, held until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      count <= '0;
      sat   <= 1'b0;
    end else if (state == HOLD && !valid) begin
      valid <= 1'b1;
      count <= ecnt;
      sat   <= esat;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

`ifdef RIP_RO_TRNG_EN
  // parity of the count with the result, raw level at window close
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_bit <= 1'b0;
      rnd_raw <= 1'b0;
    end else begin
      if (state == HOLD && !valid) begin
        rnd_bit <= ^ecnt;
      end
      if (win_end) begin
        rnd_raw <= ro_s;
      end
    end
  end
`endif

endmodule
